coef_rom_seq: RTL and testbench
===============================

Name: coef_rom_seq

Overview:
- Sequences reads from the 16-bit combinational per-channel scale-coefficient ROM used by the BWN datapath.
- On a start pulse, walks a window of ROM addresses (one per output channel), repeated once per pixel group.
- Streams each coefficient to the downstream scaling/MAC stage over a valid/ready handshake.
- Reports busy, last, done and configuration-error status to the layer controller.

Parameters:
- WIDTH_A, 12, ROM address width.
- ROM_DEPTH, 40, number of valid ROM entries (addresses 0..ROM_DEPTH-1).
- CH_W, 8, width of the channel-count field.
- PIX_W, 16, width of the pixel-group-count field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  WIDTH_A  first ROM address of the window.
- ch_count  in  CH_W  channels per pixel group.
- pix_count  in  PIX_W  number of pixel groups.
- rom_addr  out  WIDTH_A  address to ROM; registered.
- rom_coef  in  16  combinational ROM data for rom_addr.
- coef_out  out  16  registered coefficient.
- ch_idx  out  CH_W  channel index of coef_out.
- out_valid  out  1  coef_out/ch_idx/last valid.
- out_ready  in  1  downstream accepts the beat.
- last  out  1  final beat of the job.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle pulse with done when start is rejected.

Behaviour:
- Reset (async, immediate): state IDLE; all counters and rom_addr=0; coef_out=0, ch_idx=0; out_valid, last, busy, done, cfg_err all 0.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start with ch_count==0 or pix_count==0: next cycle done=1, cfg_err=0, no beats; remain IDLE.
  - start with base_addr+ch_count > ROM_DEPTH (compute at WIDTH_A+1 bits, no wrap): next cycle done=1, cfg_err=1; remain IDLE.
  - Otherwise: latch config; ch=0, pix=0, rom_addr=base_addr, busy=1; go to RUN.
- RUN, load condition load = !out_valid || out_ready:
  - On load: coef_out<=rom_coef, ch_idx<=ch, out_valid<=1, last<=(ch==ch_count-1 && pix==pix_count-1).
  - Then advance: ch increments. At ch_count-1, ch wraps to 0 and pix increments. rom_addr=base_addr+next ch.
  - After loading the final element, go to FLUSH.
  - If !load, all registers hold (ROM data re-read next cycle; stall-safe).
- FLUSH: when out_valid && out_ready && last, then out_valid=0, last=0, busy=0, done=1 for one cycle; go to IDLE.
- Latency: start sampled at edge k; out_valid is high after edge k+1.
- Throughput: 1 beat/clk with out_ready held high. Total beats = ch_count*pix_count.
- Handshake: while out_valid && !out_ready, coef_out, ch_idx and last are stable. out_valid never drops without acceptance.
- start while busy is ignored; no config change mid-job.
- rst mid-job aborts immediately: no done pulse. A new start after reset release runs normally.
- done and cfg_err never assert while out_valid is 1.

Test Plan:
- Nominal: base=0, ch=4, pix=2, out_ready=1.
  - Beats in order: 0x0013, 0x0011, 0x0014, 0x000c, then repeated.
  - ch_idx 0..3 twice; last only on beat 8.
  - First out_valid one cycle after start; done one cycle after beat 8; busy low afterwards.
- Backpressure: base=4, ch=3, pix=1; out_ready toggles 1,0,0,1,0,1.
  - Beats 0x0017, 0x0014, 0x0017; each held stable while stalled.
  - No beat lost or duplicated; exactly 3 handshakes.
- Window at top: base=36, ch=4, pix=1 → beats 0x0012, 0x000e, 0x0013, 0x0015; last on 0x0015.
- Config reject and zero count:
  - base=36, ch=5 → done=1, cfg_err=1 next cycle, out_valid never 1.
  - ch=0 → done=1, cfg_err=0, no beats.
- Busy/reset:
  - Second start mid-job (base=10) is ignored; the stream continues from the original base.
  - Assert rst mid-beat → out_valid, busy, coef_out go to 0 asynchronously.
  - Restart with base=28, ch=1, pix=1 → single beat 0x001f with last=1.

Source files
------------

// File: rtl/coef_rom_seq_if.sv
// Handshake/config bundle between the layer controller, coefficient ROM and
// the downstream scaling stage. The master side drives config, ROM data and ready.
interface coef_rom_seq_if #(
  parameter int WIDTH_A = 12,
  parameter int CH_W    = 8,
  parameter int PIX_W   = 16
);
  logic               start;
  logic [WIDTH_A-1:0] base_addr;
  logic [CH_W-1:0]    ch_count;
  logic [PIX_W-1:0]   pix_count;
  logic [WIDTH_A-1:0] rom_addr;
  logic [15:0]        rom_coef;
  logic [15:0]        coef_out;
  logic [CH_W-1:0]    ch_idx;
  logic               out_valid;
  logic               out_ready;
  logic               last;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output start, base_addr, ch_count, pix_count, rom_coef, out_ready,
    input  rom_addr, coef_out, ch_idx, out_valid, last, busy, done, cfg_err
  );

  modport slave (
    input  start, base_addr, ch_count, pix_count, rom_coef, out_ready,
    output rom_addr, coef_out, ch_idx, out_valid, last, busy, done, cfg_err
  );
endinterface

// File: rtl/coef_rom_seq.sv
// Walks a window of per-channel scale coefficients once per pixel group and
// streams them over valid/ready; rom_addr always points at the next beat to load.
module coef_rom_seq #(
  parameter int WIDTH_A   = 12,
  parameter int ROM_DEPTH = 40,
  parameter int CH_W      = 8,
  parameter int PIX_W     = 16
) (
  input  logic           clk,
  input  logic           rst,
  coef_rom_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [WIDTH_A-1:0] base_r, base_nxt;
  logic [CH_W-1:0]    chc_r, chc_nxt;
  logic [PIX_W-1:0]   pixc_r, pixc_nxt;
  logic [CH_W-1:0]    ch_r, ch_nxt;
  logic [PIX_W-1:0]   pix_r, pix_nxt;
  logic [WIDTH_A-1:0] rom_addr_r, rom_addr_nxt;
  logic [15:0]        coef_r, coef_nxt;
  logic [CH_W-1:0]    ch_idx_r, ch_idx_nxt;
  logic               valid_r, valid_nxt;
  logic               last_r, last_nxt;
  logic               busy_r, busy_nxt;
  logic               done_r, done_nxt;
  logic               err_r, err_nxt;

  logic               load;
  logic               ch_wrap;
  logic               final_elem;
  logic [CH_W-1:0]    ch_adv;
  logic [WIDTH_A:0]   win_end;

  // One extra bit so a window running past the top of the address space cannot wrap.
  assign win_end    = {1'b0, bus.base_addr} + (WIDTH_A+1)'(bus.ch_count);
  assign load       = !valid_r || bus.out_ready;
  assign ch_wrap    = (ch_r == chc_r - CH_W'(1));
  assign final_elem = ch_wrap && (pix_r == pixc_r - PIX_W'(1));
  assign ch_adv     = ch_wrap ? '0 : ch_r + CH_W'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    base_nxt     = base_r;
    chc_nxt      = chc_r;
    pixc_nxt     = pixc_r;
    ch_nxt       = ch_r;
    pix_nxt      = pix_r;
    rom_addr_nxt = rom_addr_r;
    coef_nxt     = coef_r;
    ch_idx_nxt   = ch_idx_r;
    valid_nxt    = valid_r;
    last_nxt     = last_r;
    busy_nxt     = busy_r;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.ch_count == '0 || bus.pix_count == '0) begin
            done_nxt = 1'b1;
          end else if (win_end > (WIDTH_A+1)'(ROM_DEPTH)) begin
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
          end else begin
            base_nxt     = bus.base_addr;
            chc_nxt      = bus.ch_count;
            pixc_nxt     = bus.pix_count;
            ch_nxt       = '0;
            pix_nxt      = '0;
            rom_addr_nxt = bus.base_addr;
            busy_nxt     = 1'b1;
            state_nxt    = RUN;
          end
        end
      end

      RUN: begin
        // Without load everything holds, so the ROM is simply re-read next cycle.
        if (load) begin
          coef_nxt     = bus.rom_coef;
          ch_idx_nxt   = ch_r;
          valid_nxt    = 1'b1;
          last_nxt     = final_elem;
          ch_nxt       = ch_adv;
          pix_nxt      = ch_wrap ? pix_r + PIX_W'(1) : pix_r;
          rom_addr_nxt = base_r + WIDTH_A'(ch_adv);
          if (final_elem) state_nxt = FLUSH;
        end
      end

      FLUSH: begin
        if (valid_r && bus.out_ready && last_r) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_r     <= '0;
      chc_r      <= '0;
      pixc_r     <= '0;
      ch_r       <= '0;
      pix_r      <= '0;
      rom_addr_r <= '0;
      coef_r     <= '0;
      ch_idx_r   <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state      <= state_nxt;
      base_r     <= base_nxt;
      chc_r      <= chc_nxt;
      pixc_r     <= pixc_nxt;
      ch_r       <= ch_nxt;
      pix_r      <= pix_nxt;
      rom_addr_r <= rom_addr_nxt;
      coef_r     <= coef_nxt;
      ch_idx_r   <= ch_idx_nxt;
      valid_r    <= valid_nxt;
      last_r     <= last_nxt;
      busy_r     <= busy_nxt;
      done_r     <= done_nxt;
      err_r      <= err_nxt;
    end
  end

  assign bus.rom_addr  = rom_addr_r;
  assign bus.coef_out  = coef_r;
  assign bus.ch_idx    = ch_idx_r;
  assign bus.out_valid = valid_r;
  assign bus.last      = last_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.cfg_err   = err_r;

endmodule

// File: tb/tb_coef_rom_seq.sv
// Bench for coef_rom_seq: directed and randomized jobs checked against a
// ROM-table model that lists the expected beats of each job up front.
module tb_coef_rom_seq;
  localparam int WIDTH_A   = 12;
  localparam int ROM_DEPTH = 40;
  localparam int CH_W      = 8;
  localparam int PIX_W     = 16;

  typedef struct packed {
    logic [15:0]     coef;
    logic [CH_W-1:0] idx;
    logic            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coef_rom_seq_if #(.WIDTH_A(WIDTH_A), .CH_W(CH_W), .PIX_W(PIX_W)) bus ();

  coef_rom_seq #(
    .WIDTH_A(WIDTH_A), .ROM_DEPTH(ROM_DEPTH), .CH_W(CH_W), .PIX_W(PIX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] rom [ROM_DEPTH];
  assign bus.rom_coef = (bus.rom_addr < WIDTH_A'(ROM_DEPTH)) ? rom[bus.rom_addr[5:0]] : 16'hdead;

  beat_t exp_q[$];
  int    n_pass   = 0;
  int    n_fail   = 0;
  int    n_total  = 0;
  int    hs_total = 0;
  logic  stalled  = 1'b0;
  beat_t held     = '0;
  bit    bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected stream of a legal job: every pixel group replays the channel window.
  task automatic push_job(input int base, input int chc, input int pixc);
    beat_t b;
    for (int p = 0; p < pixc; p++) begin
      for (int c = 0; c < chc; c++) begin
        b.coef = rom[base + c];
        b.idx  = CH_W'(c);
        b.last = (p == pixc - 1) && (c == chc - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Beat monitor, sampling on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_coef",  bus.coef_out,  held.coef);
        check("hold_idx",   bus.ch_idx,    held.idx);
        check("hold_last",  bus.last,      held.last);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("beat_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat_coef", bus.coef_out, e.coef);
          check("beat_idx",  bus.ch_idx,   e.idx);
          check("beat_last", bus.last,     e.last);
        end
        hs_total <= hs_total + 1;
      end
      if (bus.done || bus.cfg_err) check("status_vs_valid", bus.out_valid, 0);
      stalled <= bus.out_valid && !bus.out_ready;
      held    <= '{coef: bus.coef_out, idx: bus.ch_idx, last: bus.last};
    end
  end

  // rmode: 0 = ready held high, 1 = fixed toggle pattern, 2 = random ready.
  task automatic run_job(input int base, input int chc, input int pixc,
                         input int rmode, input int inject_at);
    int exp_beats = 0;
    int exp_err   = 0;
    int hs0;
    bit got_done  = 1'b0;
    if (chc != 0 && pixc != 0) begin
      if (base + chc > ROM_DEPTH) exp_err = 1;
      else begin
        push_job(base, chc, pixc);
        exp_beats = chc * pixc;
      end
    end
    hs0 = hs_total;
    bus.base_addr = WIDTH_A'(base);
    bus.ch_count  = CH_W'(chc);
    bus.pix_count = PIX_W'(pixc);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;

    if (exp_beats == 0) begin
      check("rej_done",  bus.done,      1);
      check("rej_err",   bus.cfg_err,   exp_err);
      check("rej_busy",  bus.busy,      0);
      check("rej_valid", bus.out_valid, 0);
      @(posedge clk); #1;
      check("rej_done_pulse", bus.done,      0);
      check("rej_no_beats",   hs_total - hs0, 0);
      check("rej_valid2",     bus.out_valid, 0);
    end else begin
      check("acc_busy",  bus.busy,      1);
      check("acc_valid", bus.out_valid, 0);
      for (int i = 0; i < 4000 && !got_done; i++) begin
        case (rmode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = (i < 6) ? bp_pat[i] : 1'b1;
          default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        if (i == inject_at) begin
          bus.start     = 1'b1;
          bus.base_addr = WIDTH_A'(10);
        end
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.base_addr = WIDTH_A'(base);
        if (i == 0) begin
          check("first_valid", bus.out_valid, 1);
          check("run_busy",    bus.busy,      1);
        end
        if (bus.done) got_done = 1'b1;
      end
      check("done_seen",   got_done,        1);
      check("done_err",    bus.cfg_err,     0);
      check("busy_after",  bus.busy,        0);
      check("valid_after", bus.out_valid,   0);
      check("hs_count",    hs_total - hs0,  exp_beats);
      check("queue_empty", exp_q.size(),    0);
    end
  endtask

  initial begin
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 16'h0040 + 16'(i * 3);
    rom[0]  = 16'h0013; rom[1]  = 16'h0011; rom[2]  = 16'h0014; rom[3]  = 16'h000c;
    rom[4]  = 16'h0017; rom[5]  = 16'h0014; rom[6]  = 16'h0017; rom[28] = 16'h001f;
    rom[36] = 16'h0012; rom[37] = 16'h000e; rom[38] = 16'h0013; rom[39] = 16'h0015;

    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.ch_count  = '0;
    bus.pix_count = '0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_valid",    bus.out_valid, 0);
    check("rst_busy",     bus.busy,      0);
    check("rst_done",     bus.done,      0);
    check("rst_err",      bus.cfg_err,   0);
    check("rst_last",     bus.last,      0);
    check("rst_coef",     bus.coef_out,  0);
    check("rst_idx",      bus.ch_idx,    0);
    check("rst_rom_addr", bus.rom_addr,  0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(0, 4, 2, 0, -1);   // nominal
    run_job(4, 3, 1, 1, -1);   // backpressure pattern
    run_job(36, 4, 1, 0, -1);  // window ending exactly at the top
    run_job(36, 5, 1, 0, -1);  // window past the top: rejected
    run_job(5, 0, 3, 0, -1);   // zero channels
    run_job(5, 3, 0, 0, -1);   // zero pixel groups
    run_job(0, 4, 2, 0, 2);    // second start mid-job is ignored
    run_job(35, 5, 2, 2, -1);  // boundary window, random ready

    // Reset in the middle of a job aborts it without a done pulse.
    push_job(0, 4, 2);
    bus.base_addr = '0;
    bus.ch_count  = CH_W'(4);
    bus.pix_count = PIX_W'(2);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_busy",  bus.busy,      0);
    check("arst_coef",  bus.coef_out,  0);
    check("arst_last",  bus.last,      0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_done",  bus.done,      0);
      check("post_rst_valid", bus.out_valid, 0);
    end
    run_job(28, 1, 1, 0, -1);

    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(0, 39)), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 3)), 2, -1);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
